// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with per-operand bypass muxing.
// Each decoded operand (Rs/Rt/Rd) is chosen from regfile, EX result or MEM
// result and latched into EX. Stall/flush/invalid inject bubbles, freeze holds
// the whole stage. EX-side dst/write/float/wbsrc feed back to the forwarding
// unit. bubble_cnt counts stall-inserted bubbles only, saturating.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_rd_data,
    input  logic [1:0]        fw_rs,
    input  logic [1:0]        fw_rt,
    input  logic [1:0]        fw_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              freeze,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_op,
    input  logic [4:0]        id_dst,
    input  logic              id_write,
    input  logic              id_float,
    input  logic [1:0]        id_wbsrc,
    input  logic              id_mem_write,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_rd_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic [4:0]        ex_dst,
    output logic              ex_write,
    output logic              ex_float,
    output logic [1:0]        ex_wbsrc,
    output logic              ex_mem_write,
    output logic              if_id_hold,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // Bypass select decode: 1 -> EX result, 2 -> MEM result, 0/3 -> regfile.
    function automatic logic [DATA_W-1:0] bypass_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf_data,
        input logic [DATA_W-1:0] ex_data,
        input logic [DATA_W-1:0] mem_data
    );
        logic [DATA_W-1:0] res;
        case (sel)
            SEL_EX:  res = ex_data;
            SEL_MEM: res = mem_data;
            default: res = rf_data;
        endcase
        return res;
    endfunction

    // Bypassed operands (combinational, current cycle)
    logic [DATA_W-1:0] rs_mux_s;
    logic [DATA_W-1:0] rt_mux_s;
    logic [DATA_W-1:0] rd_mux_s;

    // Control decode
    logic              load_bubble_s;
    logic              count_bubble_s;
    logic              cnt_full_s;

    // Next-state values for the EX stage
    logic              nxt_valid_s;
    logic [DATA_W-1:0] nxt_rs_s;
    logic [DATA_W-1:0] nxt_rt_s;
    logic [DATA_W-1:0] nxt_rd_s;
    logic [DATA_W-1:0] nxt_imm_s;
    logic [3:0]        nxt_alu_op_s;
    logic [4:0]        nxt_dst_s;
    logic              nxt_write_s;
    logic              nxt_float_s;
    logic [1:0]        nxt_wbsrc_s;
    logic              nxt_mem_write_s;

    // EX-stage state
    logic              valid_r;
    logic [DATA_W-1:0] rs_r;
    logic [DATA_W-1:0] rt_r;
    logic [DATA_W-1:0] rd_r;
    logic [DATA_W-1:0] imm_r;
    logic [3:0]        alu_op_r;
    logic [4:0]        dst_r;
    logic              write_r;
    logic              float_r;
    logic [1:0]        wbsrc_r;
    logic              mem_write_r;
    logic [CNT_W-1:0]  cnt_r;

    // Independent operand bypass muxes
    always_comb begin
        rs_mux_s = bypass_sel(fw_rs, id_rs_data, ex_fwd_data, mem_fwd_data);
        rt_mux_s = bypass_sel(fw_rt, id_rt_data, ex_fwd_data, mem_fwd_data);
        rd_mux_s = bypass_sel(fw_rd, id_rd_data, ex_fwd_data, mem_fwd_data);
    end

    // Bubble and counter decisions; freeze gating is applied at the registers
    always_comb begin
        load_bubble_s  = flush | stall | ~id_valid;
        cnt_full_s     = (cnt_r == {CNT_W{1'b1}});
        count_bubble_s = stall & ~flush & ~freeze & ~cnt_full_s;
    end

    // Next EX contents: either a full bubble or the muxed ID instruction
    always_comb begin
        nxt_valid_s     = 1'b0;
        nxt_rs_s        = {DATA_W{1'b0}};
        nxt_rt_s        = {DATA_W{1'b0}};
        nxt_rd_s        = {DATA_W{1'b0}};
        nxt_imm_s       = {DATA_W{1'b0}};
        nxt_alu_op_s    = 4'd0;
        nxt_dst_s       = 5'd0;
        nxt_write_s     = 1'b0;
        nxt_float_s     = 1'b0;
        nxt_wbsrc_s     = 2'd0;
        nxt_mem_write_s = 1'b0;
        if (!load_bubble_s) begin
            nxt_valid_s     = 1'b1;
            nxt_rs_s        = rs_mux_s;
            nxt_rt_s        = rt_mux_s;
            nxt_rd_s        = rd_mux_s;
            nxt_imm_s       = id_imm;
            nxt_alu_op_s    = id_alu_op;
            nxt_dst_s       = id_dst;
            nxt_write_s     = id_write;
            nxt_float_s     = id_float;
            nxt_wbsrc_s     = id_wbsrc;
            nxt_mem_write_s = id_mem_write;
        end else begin
            nxt_valid_s     = 1'b0;
        end
    end

    // EX-stage register bank: freeze holds everything, otherwise load next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            rs_r        <= {DATA_W{1'b0}};
            rt_r        <= {DATA_W{1'b0}};
            rd_r        <= {DATA_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            alu_op_r    <= 4'd0;
            dst_r       <= 5'd0;
            write_r     <= 1'b0;
            float_r     <= 1'b0;
            wbsrc_r     <= 2'd0;
            mem_write_r <= 1'b0;
        end else if (!freeze) begin
            valid_r     <= nxt_valid_s;
            rs_r        <= nxt_rs_s;
            rt_r        <= nxt_rt_s;
            rd_r        <= nxt_rd_s;
            imm_r       <= nxt_imm_s;
            alu_op_r    <= nxt_alu_op_s;
            dst_r       <= nxt_dst_s;
            write_r     <= nxt_write_s;
            float_r     <= nxt_float_s;
            wbsrc_r     <= nxt_wbsrc_s;
            mem_write_r <= nxt_mem_write_s;
        end else begin
            valid_r     <= valid_r;
            rs_r        <= rs_r;
            rt_r        <= rt_r;
            rd_r        <= rd_r;
            imm_r       <= imm_r;
            alu_op_r    <= alu_op_r;
            dst_r       <= dst_r;
            write_r     <= write_r;
            float_r     <= float_r;
            wbsrc_r     <= wbsrc_r;
            mem_write_r <= mem_write_r;
        end
    end

    // Saturating count of load-use bubbles (flush-killed bubbles excluded)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (count_bubble_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Upstream hold is purely combinational so IF/ID freezes in the same cycle
    assign if_id_hold   = stall | freeze;

    assign ex_valid     = valid_r;
    assign ex_rs_val    = rs_r;
    assign ex_rt_val    = rt_r;
    assign ex_rd_val    = rd_r;
    assign ex_imm       = imm_r;
    assign ex_alu_op    = alu_op_r;
    assign ex_dst       = dst_r;
    assign ex_write     = write_r;
    assign ex_float     = float_r;
    assign ex_wbsrc     = wbsrc_r;
    assign ex_mem_write = mem_write_r;
    assign bubble_cnt   = cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized
// traffic, checked against a behavioural model of the pipeline register.
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int VEC_W  = 1 + 4*DATA_W + 4 + 5 + 1 + 1 + 2 + 1 + CNT_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_rd_data;
    logic [1:0]        fw_rs, fw_rt, fw_rd;
    logic [DATA_W-1:0] ex_fwd_data, mem_fwd_data;
    logic              stall, flush, freeze;
    logic [DATA_W-1:0] id_imm;
    logic [3:0]        id_alu_op;
    logic [4:0]        id_dst;
    logic              id_write, id_float, id_mem_write;
    logic [1:0]        id_wbsrc;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rs_val, ex_rt_val, ex_rd_val, ex_imm;
    logic [3:0]        ex_alu_op;
    logic [4:0]        ex_dst;
    logic              ex_write, ex_float, ex_mem_write;
    logic [1:0]        ex_wbsrc;
    logic              if_id_hold;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic              m_valid;
    logic [DATA_W-1:0] m_rs, m_rt, m_rd, m_imm;
    logic [3:0]        m_alu_op;
    logic [4:0]        m_dst;
    logic              m_write, m_float, m_mem_write;
    logic [1:0]        m_wbsrc;
    int                m_cnt;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rd_data(id_rd_data),
        .fw_rs(fw_rs), .fw_rt(fw_rt), .fw_rd(fw_rd),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
        .stall(stall), .flush(flush), .freeze(freeze),
        .id_imm(id_imm), .id_alu_op(id_alu_op), .id_dst(id_dst),
        .id_write(id_write), .id_float(id_float), .id_wbsrc(id_wbsrc),
        .id_mem_write(id_mem_write),
        .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_rd_val(ex_rd_val), .ex_imm(ex_imm), .ex_alu_op(ex_alu_op),
        .ex_dst(ex_dst), .ex_write(ex_write), .ex_float(ex_float),
        .ex_wbsrc(ex_wbsrc), .ex_mem_write(ex_mem_write),
        .if_id_hold(if_id_hold), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
        if (sel == 2'd1) return ex_fwd_data;
        if (sel == 2'd2) return mem_fwd_data;
        return rf;
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {ex_valid, ex_rs_val, ex_rt_val, ex_rd_val, ex_imm, ex_alu_op, ex_dst,
                ex_write, ex_float, ex_wbsrc, ex_mem_write, bubble_cnt};
    endfunction

    function automatic logic [VEC_W-1:0] model_vec();
        logic [CNT_W-1:0] c;
        c = CNT_W'(m_cnt);
        return {m_valid, m_rs, m_rt, m_rd, m_imm, m_alu_op, m_dst,
                m_write, m_float, m_wbsrc, m_mem_write, c};
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0; m_imm = '0;
        m_alu_op = 4'd0; m_dst = 5'd0; m_write = 1'b0; m_float = 1'b0;
        m_wbsrc = 2'd0; m_mem_write = 1'b0;
    endtask

    // Apply the stage rules for the current inputs, then clock the DUT.
    task automatic tick();
        if (!freeze) begin
            if (flush || stall || !id_valid) begin
                model_clear();
                if (stall && !flush && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end else begin
                m_valid = 1'b1;
                m_rs = pick(fw_rs, id_rs_data);
                m_rt = pick(fw_rt, id_rt_data);
                m_rd = pick(fw_rd, id_rd_data);
                m_imm = id_imm; m_alu_op = id_alu_op; m_dst = id_dst;
                m_write = id_write; m_float = id_float; m_wbsrc = id_wbsrc;
                m_mem_write = id_mem_write;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_rd_data = '0;
        fw_rs = 2'd0; fw_rt = 2'd0; fw_rd = 2'd0; ex_fwd_data = '0; mem_fwd_data = '0;
        stall = 1'b0; flush = 1'b0; freeze = 1'b0; id_imm = '0; id_alu_op = 4'd0;
        id_dst = 5'd0; id_write = 1'b0; id_float = 1'b0; id_wbsrc = 2'd0; id_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        m_cnt = 0;
        #12;
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), model_vec());
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_rs [4];
        exp_rs[0] = 32'h11; exp_rs[1] = 32'h22; exp_rs[2] = 32'h33; exp_rs[3] = 32'h11;
        idle_inputs();
        id_valid = 1'b1;
        id_rs_data = 32'h11; id_rt_data = 32'h44; id_rd_data = 32'h55;
        ex_fwd_data = 32'h22; mem_fwd_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            fw_rs = 2'(i); fw_rt = 2'((i + 1) % 4); fw_rd = 2'((i + 2) % 4);
            tick();
            n_vec++;
            if (ex_rs_val !== exp_rs[i]) begin
                n_err++;
                $display("FAIL bypass_rs[%0d]: got %h want %h", i, ex_rs_val, exp_rs[i]);
            end
            n_vec++;
            if ({ex_rt_val, ex_rd_val} !== {m_rt, m_rd}) begin
                n_err++;
                $display("FAIL bypass_rt_rd[%0d]: got %h/%h want %h/%h", i, ex_rt_val, ex_rd_val, m_rt, m_rd);
            end
        end
    endtask

    task automatic test_load_use();
        int cnt_before;
        cnt_before = m_cnt;
        idle_inputs();
        id_valid = 1'b1; id_write = 1'b1; id_dst = 5'd5; stall = 1'b1;
        #1;
        n_vec++;
        if (if_id_hold !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_hold: got %b want 1", if_id_hold);
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_write, ex_dst, bubble_cnt} !== {1'b0, 1'b0, 5'd0, CNT_W'(cnt_before + 1)}) begin
            n_err++;
            $display("FAIL load_use_bubble: got v=%b w=%b d=%0d c=%0d want v=0 w=0 d=0 c=%0d",
                     ex_valid, ex_write, ex_dst, bubble_cnt, cnt_before + 1);
        end
        stall = 1'b0; fw_rs = 2'd2; mem_fwd_data = 32'hABCD;
        tick();
        n_vec++;
        if ({ex_rs_val, ex_dst, ex_valid} !== {32'hABCD, 5'd5, 1'b1}) begin
            n_err++;
            $display("FAIL load_use_resume: got rs=%h dst=%0d v=%b want rs=0000abcd dst=5 v=1",
                     ex_rs_val, ex_dst, ex_valid);
        end
    endtask

    task automatic test_freeze();
        logic [VEC_W-1:0] held;
        idle_inputs();
        id_valid = 1'b1; id_rs_data = 32'hCAFE0001; id_imm = 32'h7; id_alu_op = 4'd9;
        id_dst = 5'd17; id_write = 1'b1; id_wbsrc = 2'd1;
        tick();
        held = model_vec();
        id_rs_data = 32'hBEEF0002; id_dst = 5'd3; id_alu_op = 4'd2;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stall = (i != 1); flush = (i == 1);
            #1;
            n_vec++;
            if (if_id_hold !== 1'b1) begin
                n_err++;
                $display("FAIL freeze_hold[%0d]: got %b want 1", i, if_id_hold);
            end
            tick();
            n_vec++;
            if (dut_vec() !== held) begin
                n_err++;
                $display("FAIL freeze_state[%0d]: got %h want %h", i, dut_vec(), held);
            end
        end
        freeze = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        n_vec++;
        if ({ex_valid, ex_rs_val, ex_dst, ex_alu_op} !== {1'b1, 32'hBEEF0002, 5'd3, 4'd2}) begin
            n_err++;
            $display("FAIL freeze_release: got v=%b rs=%h dst=%0d op=%0d want v=1 rs=beef0002 dst=3 op=2",
                     ex_valid, ex_rs_val, ex_dst, ex_alu_op);
        end
    endtask

    task automatic test_flush_vs_stall();
        int cnt_before;
        cnt_before = m_cnt;
        idle_inputs();
        id_valid = 1'b1; id_write = 1'b1; id_dst = 5'd9; stall = 1'b1; flush = 1'b1;
        #1;
        n_vec++;
        if (if_id_hold !== 1'b1) begin
            n_err++;
            $display("FAIL flush_stall_hold: got %b want 1", if_id_hold);
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_write, bubble_cnt} !== {1'b0, 1'b0, CNT_W'(cnt_before)}) begin
            n_err++;
            $display("FAIL flush_stall_bubble: got v=%b w=%b c=%0d want v=0 w=0 c=%0d",
                     ex_valid, ex_write, bubble_cnt, cnt_before);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs_data = $urandom; id_rt_data = $urandom; id_rd_data = $urandom;
            ex_fwd_data = $urandom; mem_fwd_data = $urandom; id_imm = $urandom;
            fw_rs = 2'($urandom); fw_rt = 2'($urandom); fw_rd = 2'($urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 6) == 0);
            id_alu_op = 4'($urandom); id_dst = 5'($urandom); id_write = 1'($urandom);
            id_float = 1'($urandom); id_wbsrc = 2'($urandom); id_mem_write = 1'($urandom);
            #1;
            n_vec++;
            if (if_id_hold !== (stall | freeze)) begin
                n_err++;
                $display("FAIL random_hold[%0d]: got %b want %b", i, if_id_hold, stall | freeze);
            end
            tick();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++;
                $display("FAIL random_state[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        id_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (bubble_cnt !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL sat_step[%0d]: got %0d want %0d", i, bubble_cnt, m_cnt);
            end
        end
        n_vec++;
        if (bubble_cnt !== 4'hF) begin
            n_err++;
            $display("FAIL sat_final: got %h want f", bubble_cnt);
        end
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        id_valid = 1'b1; id_write = 1'b1; id_dst = 5'd12; id_rs_data = 32'h1234;
        tick();
        n_vec++;
        if ({ex_valid, ex_write} !== 2'b11) begin
            n_err++;
            $display("FAIL async_pre: got v=%b w=%b want 1/1", ex_valid, ex_write);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        m_cnt = 0;
        #1;
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), model_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL post_reset: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_freeze();
        test_flush_vs_stall();
        test_random();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
